// File: rtl/key_accum_ctrl_if.sv
// -----------------------------------------------------------------------------
// key_accum_ctrl_if
// Bundles the board-facing signals of the key accumulator controller.
//   key_acc_n  raw accumulate pushbutton, active-low, asynchronous
//   key_clr_n  raw clear pushbutton, active-low, asynchronous
//   sw         slide-switch operand, asynchronous, quasi-static
//   led        accumulator value
//   ovf        sticky overflow flag
//   busy       controller not idle
//   add_done   one-cycle pulse when led takes a new summed value
// master: board / stimulus side.  slave: the controller.
// -----------------------------------------------------------------------------
interface key_accum_ctrl_if #(
    parameter int unsigned WIDTH = 8
);
    logic             key_acc_n;
    logic             key_clr_n;
    logic [WIDTH-1:0] sw;
    logic [WIDTH-1:0] led;
    logic             ovf;
    logic             busy;
    logic             add_done;

    modport master (
        output key_acc_n,
        output key_clr_n,
        output sw,
        input  led,
        input  ovf,
        input  busy,
        input  add_done
    );

    modport slave (
        input  key_acc_n,
        input  key_clr_n,
        input  sw,
        output led,
        output ovf,
        output busy,
        output add_done
    );
endinterface

// File: rtl/key_accum_ctrl.sv
// -----------------------------------------------------------------------------
// key_accum_ctrl
// Hardware add/clear sequencer for the switch accumulator. Synchronizes and
// debounces the two pushbuttons, turns stable 1->0 transitions into press
// strobes and steps a WIDTH-bit accumulator through a small FSM.
// Ports:
//   Clk    system clock
//   Reset  synchronous, active-high reset
//   bus    key_accum_ctrl_if.slave (keys, switches in; led/ovf/busy/add_done out)
// -----------------------------------------------------------------------------
module key_accum_ctrl #(
    parameter int unsigned WIDTH           = 8,
    parameter int unsigned DEBOUNCE_CYCLES = 500000
) (
    input logic             Clk,
    input logic             Reset,
    key_accum_ctrl_if.slave bus
);
    localparam int unsigned CntW = $clog2(DEBOUNCE_CYCLES + 1);

    // Key index 0 = accumulate, 1 = clear.
    localparam int unsigned KeyAcc = 0;
    localparam int unsigned KeyClr = 1;

    typedef enum logic [1:0] {
        StIdle,
        StAccum,
        StClear,
        StWaitRel
    } state_t;

    logic [1:0]       r_key_meta;
    logic [1:0]       r_key_sync;
    logic [1:0]       r_key_stable;
    logic [CntW-1:0]  r_cnt [2];
    logic [WIDTH-1:0] r_sw_meta;
    logic [WIDTH-1:0] r_sw_sync;
    logic [WIDTH-1:0] r_sw_q;
    logic [WIDTH-1:0] r_led;
    logic             r_ovf;
    logic             r_add_done;
    state_t           r_state;
    state_t           w_state_next;

    logic [1:0]       w_accept;
    logic [1:0]       w_press;
    logic [WIDTH:0]   w_sum;

    // Two-flop synchronizers; keys idle high, switches idle low.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_key_meta <= '1;
            r_key_sync <= '1;
            r_sw_meta  <= '0;
            r_sw_sync  <= '0;
        end else begin
            r_key_meta <= {bus.key_clr_n, bus.key_acc_n};
            r_key_sync <= r_key_meta;
            r_sw_meta  <= bus.sw;
            r_sw_sync  <= r_sw_meta;
        end
    end

    // A change is accepted on its DEBOUNCE_CYCLES-th consecutive mismatching cycle,
    // and a press strobe fires in that same cycle.
    always_comb begin
        w_accept = '0;
        w_press  = '0;
        for (int k = 0; k < 2; k++) begin
            w_accept[k] = (r_key_sync[k] != r_key_stable[k]) &&
                          (r_cnt[k] == CntW'(DEBOUNCE_CYCLES - 1));
            w_press[k]  = w_accept[k] & ~r_key_sync[k];
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_key_stable <= '1;
            for (int k = 0; k < 2; k++) begin
                r_cnt[k] <= '0;
            end
        end else begin
            for (int k = 0; k < 2; k++) begin
                if (r_key_sync[k] == r_key_stable[k]) begin
                    r_cnt[k] <= '0;
                end else if (w_accept[k]) begin
                    r_key_stable[k] <= r_key_sync[k];
                    r_cnt[k]        <= '0;
                end else begin
                    r_cnt[k] <= r_cnt[k] + 1'b1;
                end
            end
        end
    end

    // Next-state: presses outside StIdle are simply dropped.
    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            StIdle: begin
                if (w_press[KeyClr]) begin
                    w_state_next = StClear;
                end else if (w_press[KeyAcc]) begin
                    w_state_next = StAccum;
                end
            end
            StAccum:   w_state_next = StWaitRel;
            StClear:   w_state_next = StWaitRel;
            StWaitRel: begin
                if (&r_key_stable) begin
                    w_state_next = StIdle;
                end
            end
            default:   w_state_next = StIdle;
        endcase
    end

    assign w_sum = {1'b0, r_led} + {1'b0, r_sw_q};

    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_state    <= StIdle;
            r_sw_q     <= '0;
            r_led      <= '0;
            r_ovf      <= 1'b0;
            r_add_done <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_add_done <= 1'b0;
            if (w_press[KeyAcc]) begin
                r_sw_q <= r_sw_sync;
            end
            if (r_state == StAccum) begin
                r_led      <= w_sum[WIDTH-1:0];
                r_ovf      <= r_ovf | w_sum[WIDTH];
                r_add_done <= 1'b1;
            end else if (r_state == StClear) begin
                r_led <= '0;
                r_ovf <= 1'b0;
            end
        end
    end

    assign bus.led      = r_led;
    assign bus.ovf      = r_ovf;
    assign bus.busy     = (r_state != StIdle);
    assign bus.add_done = r_add_done;
endmodule
